// File: rtl/ob_client.sv
// Order-book initiator: host cmd FIFO -> 2-cycle paced registered issue, rsp FIFO back to host.
// Latency: cmd 2 cycles to cmd_vld_r, rsp 1 cycle to host_rsp_vld; backpressure via cmd_full_r / rsp_accept.
package ob_pkg;
    typedef struct packed {
        logic [3:0]  op;
        logic [7:0]  oid;
        logic [15:0] qty;
    } cmd_t;

    typedef struct packed {
        logic [7:0] oid;
        logic [7:0] code;
    } rsp_t;
endpackage

// Power-of-two circular FIFO; head is combinational, flags are registered.
module ob_fifo #(
    parameter int W = 8,
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_dout,
    output logic         o_empty,
    output logic         o_full
);
    localparam int AW = $clog2(N);

    logic [W-1:0]  r_mem [N];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_cnt;

    always_ff @(posedge clk) begin
        if (i_push && !i_clr)
            r_mem[r_wr] <= i_din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else if (i_clr) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push)
                r_wr <= r_wr + 1'b1;
            if (i_pop)
                r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + (AW+1)'(i_push) - (AW+1)'(i_pop);
        end
    end

    assign o_dout  = r_mem[r_rd];
    assign o_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == (AW+1)'(N));
endmodule

module ob_client #(
    parameter int CMD_N = 4,
    parameter int RSP_N = 4,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_cmd_vld,
    input  ob_pkg::cmd_t      host_cmd,
    output logic              host_cmd_accept,
    input  logic              host_flush,
    output logic              cmd_vld_r,
    output ob_pkg::cmd_t      cmd_r,
    input  logic              cmd_full_r,
    input  logic              rsp_vld,
    input  ob_pkg::rsp_t      rsp,
    output logic              rsp_accept,
    output logic              host_rsp_vld,
    output ob_pkg::rsp_t      host_rsp,
    input  logic              host_rsp_accept,
    output logic [CNT_W-1:0]  issued_cnt,
    output logic [CNT_W-1:0]  retired_cnt,
    output logic              busy
);
    typedef enum logic {READY, SENT} state_t;

    state_t       r_state;
    ob_pkg::cmd_t w_cmd_head;
    logic         w_cmd_empty;
    logic         w_cmd_full;
    logic         w_rsp_empty;
    logic         w_rsp_full;
    logic         w_launch;
    logic         w_rsp_push;
    logic         w_rsp_pop;

    assign host_cmd_accept = host_cmd_vld & ~w_cmd_full & ~host_flush;
    // Launch only from READY so every decision sees cmd_full_r updated by the previous push.
    assign w_launch = (r_state == READY) & ~w_cmd_empty & ~cmd_full_r & ~host_flush;

    ob_fifo #(.W($bits(ob_pkg::cmd_t)), .N(CMD_N)) u_cmd_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (host_flush),
        .i_push  (host_cmd_accept),
        .i_din   (host_cmd),
        .i_pop   (w_launch),
        .o_dout  (w_cmd_head),
        .o_empty (w_cmd_empty),
        .o_full  (w_cmd_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= READY;
            cmd_vld_r  <= 1'b0;
            cmd_r      <= '0;
            issued_cnt <= '0;
        end else begin
            case (r_state)
                READY: begin
                    if (w_launch) begin
                        r_state    <= SENT;
                        cmd_vld_r  <= 1'b1;
                        cmd_r      <= w_cmd_head;
                        issued_cnt <= issued_cnt + 1'b1;
                    end
                end
                SENT: begin
                    r_state   <= READY;
                    cmd_vld_r <= 1'b0;
                end
                default: begin
                    r_state   <= READY;
                    cmd_vld_r <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_accept   = ~w_rsp_full;
    assign w_rsp_push   = rsp_vld & rsp_accept;
    assign host_rsp_vld = ~w_rsp_empty;
    assign w_rsp_pop    = host_rsp_vld & host_rsp_accept;

    ob_fifo #(.W($bits(ob_pkg::rsp_t)), .N(RSP_N)) u_rsp_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (1'b0),
        .i_push  (w_rsp_push),
        .i_din   (rsp),
        .i_pop   (w_rsp_pop),
        .o_dout  (host_rsp),
        .o_empty (w_rsp_empty),
        .o_full  (w_rsp_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            retired_cnt <= '0;
        else if (w_rsp_push)
            retired_cnt <= retired_cnt + 1'b1;
    end

    assign busy = ~w_cmd_empty | cmd_vld_r;
endmodule

// File: tb/tb_ob_client.sv
// Bench for ob_client: directed vector table, hand-written corner sequences, randomized run against a queue model.
module tb_ob_client;
    import ob_pkg::*;

    localparam int CMD_N = 4;
    localparam int RSP_N = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             host_cmd_vld;
    cmd_t             host_cmd;
    logic             host_cmd_accept;
    logic             host_flush;
    logic             cmd_vld_r;
    cmd_t             cmd_r;
    logic             cmd_full_r;
    logic             rsp_vld;
    rsp_t             rsp;
    logic             rsp_accept;
    logic             host_rsp_vld;
    rsp_t             host_rsp;
    logic             host_rsp_accept;
    logic [CNT_W-1:0] issued_cnt;
    logic [CNT_W-1:0] retired_cnt;
    logic             busy;

    always #5 clk = ~clk;

    ob_client #(.CMD_N(CMD_N), .RSP_N(RSP_N), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .host_cmd_vld    (host_cmd_vld),
        .host_cmd        (host_cmd),
        .host_cmd_accept (host_cmd_accept),
        .host_flush      (host_flush),
        .cmd_vld_r       (cmd_vld_r),
        .cmd_r           (cmd_r),
        .cmd_full_r      (cmd_full_r),
        .rsp_vld         (rsp_vld),
        .rsp             (rsp),
        .rsp_accept      (rsp_accept),
        .host_rsp_vld    (host_rsp_vld),
        .host_rsp        (host_rsp),
        .host_rsp_accept (host_rsp_accept),
        .issued_cnt      (issued_cnt),
        .retired_cnt     (retired_cnt),
        .busy            (busy)
    );

    typedef struct {
        logic       vld;
        cmd_t       cmd;
        logic       full;
        logic       flush;
        logic       e_vld;
        cmd_t       e_cmd;
        logic       e_acc;
        logic       e_busy;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    cmd_t seen_q[$];
    int   seen_c[$];
    vec_t tbl[16];

    // Records every issued command and the cycle in which cmd_vld_r was seen high.
    always @(negedge clk) begin
        if (!rst && cmd_vld_r) begin
            seen_q.push_back(cmd_r);
            seen_c.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        host_cmd_vld    = 1'b0;
        host_cmd        = '0;
        host_flush      = 1'b0;
        cmd_full_r      = 1'b0;
        rsp_vld         = 1'b0;
        rsp             = '0;
        host_rsp_accept = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        seen_q.delete();
        seen_c.delete();
    endtask

    function automatic cmd_t mkc(input int i);
        return cmd_t'({4'(i), 8'(i * 7 + 3), 16'(i * 1000 + 5)});
    endfunction

    function automatic rsp_t mkr(input int i);
        return rsp_t'({8'(i + 40), 8'(i * 3 + 1)});
    endfunction

    function automatic vec_t mkv(input logic v, input int ci, input logic f, input logic fl,
                                 input logic ev, input int ei, input logic ea, input logic eb);
        vec_t t;
        t.vld = v;  t.cmd = mkc(ci); t.full = f;  t.flush = fl;
        t.e_vld = ev; t.e_cmd = mkc(ei); t.e_acc = ea; t.e_busy = eb;
        return t;
    endfunction

    initial begin
        cmd_t q[$];
        rsp_t rq[$];
        rsp_t got[$];
        logic m_vld;
        cmd_t m_cmd;
        logic [CNT_W-1:0] m_iss, m_ret;
        logic e_acc, e_racc, launch;
        int k, pushed, c;
        int exp_c[4];

        // vld, cmd, full, flush | exp vld, exp cmd, exp accept, exp busy
        tbl[0]  = mkv(1, 1, 0, 0, 0, 0, 1, 0);
        tbl[1]  = mkv(1, 2, 0, 0, 0, 0, 1, 1);
        tbl[2]  = mkv(1, 3, 0, 0, 1, 1, 1, 1);
        tbl[3]  = mkv(1, 4, 0, 0, 0, 0, 1, 1);
        tbl[4]  = mkv(0, 0, 0, 0, 1, 2, 0, 1);
        tbl[5]  = mkv(0, 0, 0, 0, 0, 0, 0, 1);
        tbl[6]  = mkv(0, 0, 0, 0, 1, 3, 0, 1);
        tbl[7]  = mkv(0, 0, 0, 0, 0, 0, 0, 1);
        tbl[8]  = mkv(0, 0, 0, 0, 1, 4, 0, 1);
        tbl[9]  = mkv(0, 0, 0, 0, 0, 0, 0, 0);
        tbl[10] = mkv(1, 5, 0, 0, 0, 0, 1, 0);
        tbl[11] = mkv(0, 0, 1, 0, 0, 0, 0, 1);
        tbl[12] = mkv(0, 0, 1, 0, 0, 0, 0, 1);
        tbl[13] = mkv(0, 0, 0, 0, 0, 0, 0, 1);
        tbl[14] = mkv(0, 0, 0, 0, 1, 5, 0, 1);
        tbl[15] = mkv(0, 0, 0, 0, 0, 0, 0, 0);

        do_reset();
        @(negedge clk);
        chk("rst cmd_vld_r", 32'(cmd_vld_r), 32'd0);
        chk("rst cmd_r", 32'(cmd_r), 32'd0);
        chk("rst host_rsp_vld", 32'(host_rsp_vld), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst host_cmd_accept", 32'(host_cmd_accept), 32'd0);
        chk("rst rsp_accept", 32'(rsp_accept), 32'd1);
        chk("rst issued_cnt", 32'(issued_cnt), 32'd0);
        chk("rst retired_cnt", 32'(retired_cnt), 32'd0);
        nxt();

        for (int i = 0; i < 16; i++) begin
            host_cmd_vld = tbl[i].vld;
            host_cmd     = tbl[i].cmd;
            cmd_full_r   = tbl[i].full;
            host_flush   = tbl[i].flush;
            @(negedge clk);
            chk($sformatf("vec%0d cmd_vld_r", i), 32'(cmd_vld_r), 32'(tbl[i].e_vld));
            if (tbl[i].e_vld)
                chk($sformatf("vec%0d cmd_r", i), 32'(cmd_r), 32'(tbl[i].e_cmd));
            chk($sformatf("vec%0d accept", i), 32'(host_cmd_accept), 32'(tbl[i].e_acc));
            chk($sformatf("vec%0d busy", i), 32'(busy), 32'(tbl[i].e_busy));
            nxt();
        end
        chk("vec issued_cnt", 32'(issued_cnt), 32'd5);

        // Backpressure held cycles 3-10: B waits until cycle 11 launches it.
        do_reset();
        for (c = 0; c < 20; c++) begin
            host_cmd_vld = (c < 4);
            host_cmd     = mkc(c);
            cmd_full_r   = (c >= 3 && c <= 10);
            @(negedge clk);
            nxt();
        end
        idle_inputs();
        exp_c = '{2, 12, 14, 16};
        chk("bp count", 32'(seen_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < seen_q.size(); i++) begin
            chk($sformatf("bp cycle%0d", i), 32'(seen_c[i]), 32'(exp_c[i]));
            chk($sformatf("bp cmd%0d", i), 32'(seen_q[i]), 32'(mkc(i)));
        end

        // Command FIFO full: fifth push refused.
        do_reset();
        for (c = 0; c < 20; c++) begin
            host_cmd_vld = (c < 5);
            host_cmd     = mkc(10 + c);
            cmd_full_r   = (c < 5);
            @(negedge clk);
            if (c < 5)
                chk($sformatf("full accept%0d", c), 32'(host_cmd_accept), (c < 4) ? 32'd1 : 32'd0);
            nxt();
        end
        idle_inputs();
        chk("full count", 32'(seen_q.size()), 32'd4);
        if (seen_c.size() > 0)
            chk("full first cycle", 32'(seen_c[0]), 32'd6);
        for (int i = 0; i < 4 && i < seen_q.size(); i++)
            chk($sformatf("full cmd%0d", i), 32'(seen_q[i]), 32'(mkc(10 + i)));

        // Flush in the cycle the first command is on the bus.
        do_reset();
        for (c = 0; c < 15; c++) begin
            host_cmd_vld = (c < 3) || (c == 5);
            host_cmd     = mkc(20 + c);
            cmd_full_r   = (c < 4);
            host_flush   = (c == 5);
            @(negedge clk);
            if (c == 5) begin
                chk("flush cmd_vld_r", 32'(cmd_vld_r), 32'd1);
                chk("flush accept", 32'(host_cmd_accept), 32'd0);
            end
            if (c == 7)
                chk("flush busy", 32'(busy), 32'd0);
            nxt();
        end
        idle_inputs();
        chk("flush count", 32'(seen_q.size()), 32'd1);
        if (seen_q.size() > 0)
            chk("flush cmd", 32'(seen_q[0]), 32'(mkc(20)));
        chk("flush issued_cnt", 32'(issued_cnt), 32'd1);

        // Response buffering: host stalls, FIFO fills after 4, then drains in order.
        do_reset();
        k = 0;
        got.delete();
        for (c = 0; c < 20; c++) begin
            rsp_vld         = (k < 5);
            rsp             = mkr(k);
            host_rsp_accept = (c >= 5);
            @(negedge clk);
            if (c < 5)
                chk($sformatf("rsp accept%0d", c), 32'(rsp_accept), (c < 4) ? 32'd1 : 32'd0);
            if (c == 5) begin
                chk("rsp retired4", 32'(retired_cnt), 32'd4);
                chk("rsp accept while full", 32'(rsp_accept), 32'd0);
            end
            if (host_rsp_vld && host_rsp_accept)
                got.push_back(host_rsp);
            if (rsp_vld && rsp_accept)
                k++;
            nxt();
        end
        idle_inputs();
        chk("rsp drained", 32'(got.size()), 32'd5);
        for (int i = 0; i < 5 && i < got.size(); i++)
            chk($sformatf("rsp order%0d", i), 32'(got[i]), 32'(mkr(i)));
        chk("rsp retired5", 32'(retired_cnt), 32'd5);

        // 17 issues on a 4-bit counter wrap to 1.
        do_reset();
        pushed = 0;
        c = 0;
        while (c < 120 && !(seen_q.size() == 17 && !busy)) begin
            host_cmd_vld = (pushed < 17);
            host_cmd     = mkc(50 + pushed);
            @(negedge clk);
            if (host_cmd_accept)
                pushed++;
            nxt();
            c++;
        end
        idle_inputs();
        chk("wrap count", 32'(seen_q.size()), 32'd17);
        chk("wrap issued_cnt", 32'(issued_cnt), 32'd1);
        if (seen_q.size() == 17)
            chk("wrap last cmd", 32'(seen_q[16]), 32'(mkc(66)));

        // Asynchronous reset while SENT, then a late response is still taken.
        do_reset();
        host_cmd_vld = 1'b1;
        host_cmd     = mkc(90);
        nxt();
        host_cmd_vld = 1'b0;
        nxt();
        @(negedge clk);
        chk("arst pre vld", 32'(cmd_vld_r), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst cmd_vld_r", 32'(cmd_vld_r), 32'd0);
        chk("arst issued_cnt", 32'(issued_cnt), 32'd0);
        chk("arst busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        rsp_vld = 1'b1;
        rsp     = mkr(7);
        @(negedge clk);
        chk("arst rsp_accept", 32'(rsp_accept), 32'd1);
        nxt();
        rsp_vld = 1'b0;
        @(negedge clk);
        chk("arst host_rsp_vld", 32'(host_rsp_vld), 32'd1);
        chk("arst host_rsp", 32'(host_rsp), 32'(mkr(7)));
        chk("arst retired_cnt", 32'(retired_cnt), 32'd1);
        nxt();

        // Randomized run against a queue-level model.
        do_reset();
        q.delete();
        rq.delete();
        m_vld = 1'b0;
        m_cmd = '0;
        m_iss = '0;
        m_ret = '0;
        for (int n = 0; n < 600; n++) begin
            host_cmd_vld    = ($urandom % 3) != 0;
            host_cmd        = cmd_t'(28'($urandom));
            host_flush      = ($urandom % 20) == 0;
            cmd_full_r      = ($urandom % 4) == 0;
            rsp_vld         = ($urandom % 2) == 0;
            rsp             = rsp_t'(16'($urandom));
            host_rsp_accept = ($urandom % 3) != 0;
            @(negedge clk);
            e_acc  = host_cmd_vld && (q.size() < CMD_N) && !host_flush;
            e_racc = (rq.size() < RSP_N);
            chk("rnd accept", 32'(host_cmd_accept), 32'(e_acc));
            chk("rnd rsp_accept", 32'(rsp_accept), 32'(e_racc));
            chk("rnd host_rsp_vld", 32'(host_rsp_vld), 32'(rq.size() > 0));
            if (rq.size() > 0)
                chk("rnd host_rsp", 32'(host_rsp), 32'(rq[0]));
            chk("rnd busy", 32'(busy), 32'((q.size() > 0) || m_vld));
            chk("rnd cmd_vld_r", 32'(cmd_vld_r), 32'(m_vld));
            chk("rnd cmd_r", 32'(cmd_r), 32'(m_cmd));
            chk("rnd issued_cnt", 32'(issued_cnt), 32'(m_iss));
            chk("rnd retired_cnt", 32'(retired_cnt), 32'(m_ret));
            // A launch never directly follows another launch.
            launch = !m_vld && (q.size() > 0) && !cmd_full_r && !host_flush;
            if (launch) begin
                m_cmd = q.pop_front();
                m_iss = m_iss + 1'b1;
            end
            m_vld = launch;
            if (host_flush)
                q.delete();
            else if (e_acc)
                q.push_back(host_cmd);
            if (rq.size() > 0 && host_rsp_accept)
                void'(rq.pop_front());
            if (rsp_vld && e_racc) begin
                rq.push_back(rsp);
                m_ret = m_ret + 1'b1;
            end
            nxt();
        end
        idle_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
